rsa_stream_loader: RTL and testbench
====================================

Name: rsa_stream_loader

Overview:
- Upstream/downstream adapter for the rsa4k modular-exponentiation core.
- Assembles message, exponent and modulus from a narrow valid/ready word stream into WIDTH-bit operand registers.
- Sequences the core's reset/go/done handshake, captures cypher, and streams it back out word-serially.
- Sits between the host bus interface and rsa4k.

Parameters:
WIDTH, 4096, operand/result width in bits (must match rsa4k width)
WORD, 32, stream word width; WIDTH must be a multiple of WORD

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
in_data  in  WORD  operand word
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts in_data this cycle
out_data  out  WORD  cypher word
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts out_data
busy  out  1  high in any state other than LOAD
error  out  1  operand check failed (RSA_MOD_CHECK_EN only; tied 0 otherwise)
core_reset  out  1  active-high reset to rsa4k
core_go  out  1  go to rsa4k
message  out  WIDTH  operand register to rsa4k
exponent  out  WIDTH  operand register to rsa4k
modulus  out  WIDTH  operand register to rsa4k
core_cypher  in  WIDTH  rsa4k result
core_done  in  1  rsa4k done (level)

Behaviour:
- Reset (async, reset=0) values:
  - state=LOAD; word counter=0.
  - in_ready=0 during reset, then 1 in LOAD.
  - out_valid=0, out_data=0, busy=0, error=0, core_go=0, core_reset=1, message/exponent/modulus/result=0.
- Word order: N=WIDTH/WORD words per operand, least-significant word first. Load sequence is message words 0..N-1, then exponent 0..N-1, then modulus 0..N-1 (3N words, 384 at defaults).
- Transfer rule: a word transfers only when valid & ready are both high on a clock edge.
- LOAD:
  - in_ready=1, core_reset=1.
  - Each transfer writes in_data into word (cnt mod N) of the operand selected by cnt/N, then cnt++.
  - On the transfer with cnt==3N-1: go to START, cnt=0, in_ready=0 next cycle.
- START (1 cycle): core_reset=0, core_go=0; next state RUN.
- RUN:
  - core_go=1, held until core_done is sampled high.
  - On that edge: result<=core_cypher, core_go<=0, state<=UNLOAD.
  - core_done high in START is ignored.
- UNLOAD:
  - out_valid=1, out_data=result word cnt.
  - cnt++ on each out transfer; out_data holds stable while out_ready=0.
  - After word N-1 transfers: out_valid<=0, cnt<=0, core_reset<=1, state<=LOAD.
- Latency:
  - Last input word to core_go high: 2 cycles.
  - core_done sampled to first out_valid: 1 cycle.
- Counter: log2(3N)+1 bits, never wraps past 3N-1; no back-to-back operand overlap (in_ready=0 outside LOAD).
- Async reset mid-operation (any state) aborts immediately: core_go drops, core_reset asserts, partial operands and results are discarded, state returns to LOAD with cnt=0.
- Operands remain stable on message/exponent/modulus from START until the next LOAD transfer overwrites them.

Optional Feature:
RSA_MOD_CHECK_EN:
- With the macro defined, the loader runs a word-serial check during modulus load. As modulus word i arrives (LSW first) it updates lt <= (msg_w < mod_w) | ((msg_w == mod_w) & lt), where msg_w is message word i and mod_w is modulus word i. It also records modulus bit 0.
- After the last modulus word: if !lt (message >= modulus) or modulus is even, error<=1 and the loader skips START/RUN. It goes directly to UNLOAD with result=0; core_go is never asserted.
- error clears on the next accepted input word or on reset.
- Without the macro: no check logic, error tied 0, every load runs the core.

Test Plan:
1. Load message=8, exponent=13, modulus=77 (all upper words 0) with in_valid held high, core responding -> core_go rises 2 cycles after word 383; out_data word0=0x32 (50), words1..127=0; busy=0 after the last out transfer.
2. Feed result 50 with exponent=37, modulus=77 -> out word0=0x08, remaining words 0 (decrypt round trip).
3. Toggle in_valid every other cycle and hold out_ready low for 5 cycles mid-unload -> same result as test 1; out_data stable while stalled; no word lost or duplicated.
4. Assert reset=0 while in RUN, then reload test 1 operands -> core_go drops the same cycle as reset asserts, core_reset=1, cnt=0; second run returns 0x32.
5. RSA_MOD_CHECK_EN: message=80, modulus=77 -> error=1, core_go never high, 128 zero words streamed. Modulus=78 with message=8 -> error=1. Without the macro, the same stimulus runs the core and error=0.
6. core_done pulsed high during START -> ignored; result captured only from done in RUN.

Source files
------------

// File: rtl/rsa_stream_loader.sv
// Word-serial operand loader and result unloader wrapped around the rsa4k core.
// Optional macro RSA_MOD_CHECK_EN adds a message<modulus / odd-modulus check during modulus load.
module rsa_stream_loader #(
    parameter int WIDTH = 4096,
    parameter int WORD  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WORD-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WORD-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             error,
    output logic             core_reset,
    output logic             core_go,
    output logic [WIDTH-1:0] message,
    output logic [WIDTH-1:0] exponent,
    output logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] core_cypher,
    input  logic             core_done
);
    localparam int N  = WIDTH / WORD;
    localparam int CW = $clog2(3 * N) + 1;
    localparam logic [CW-1:0] C_N    = CW'(N);
    localparam logic [CW-1:0] C_2N   = CW'(2 * N);
    localparam logic [CW-1:0] C_NM1  = CW'(N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(3 * N - 1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_RUN, S_UNLOAD} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready, r_out_valid, r_core_go, r_core_reset;
    logic [WIDTH-1:0] r_msg, r_exp, r_mod, r_result;
    logic             w_in_xfer, w_out_xfer, w_load_last, w_unload_last, w_chk_fail;
    logic [1:0]       w_sel;
    logic [CW-1:0]    w_idx;

    assign w_in_xfer     = in_valid & r_in_ready & (r_state == S_LOAD);
    assign w_out_xfer    = r_out_valid & out_ready & (r_state == S_UNLOAD);
    assign w_load_last   = w_in_xfer & (r_cnt == C_LAST);
    assign w_unload_last = w_out_xfer & (r_cnt == C_NM1);

    // Split the load counter into operand select and word index within it.
    always_comb begin
        w_sel = 2'd0;
        w_idx = r_cnt;
        if (r_cnt >= C_2N) begin
            w_sel = 2'd2;
            w_idx = r_cnt - C_2N;
        end else if (r_cnt >= C_N) begin
            w_sel = 2'd1;
            w_idx = r_cnt - C_N;
        end
    end

`ifdef RSA_MOD_CHECK_EN
    logic            r_lt, r_mod_odd, r_error;
    logic            w_lt_in, w_lt_nxt, w_odd_nxt;
    logic [WORD-1:0] w_msg_w;

    // LSW first: a higher word's strict compare overrides everything below it.
    assign w_msg_w    = r_msg[w_idx*WORD +: WORD];
    assign w_lt_in    = (w_idx == '0) ? 1'b0 : r_lt;
    assign w_lt_nxt   = (w_msg_w < in_data) | ((w_msg_w == in_data) & w_lt_in);
    assign w_odd_nxt  = (w_idx == '0) ? in_data[0] : r_mod_odd;
    assign w_chk_fail = ~w_lt_nxt | ~w_odd_nxt;
    assign error      = r_error;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lt      <= 1'b0;
            r_mod_odd <= 1'b0;
            r_error   <= 1'b0;
        end else if (w_in_xfer) begin
            r_error <= w_load_last & w_chk_fail;
            if (w_sel == 2'd2) begin
                r_lt      <= w_lt_nxt;
                r_mod_odd <= w_odd_nxt;
            end
        end
    end
`else
    assign w_chk_fail = 1'b0;
    assign error      = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:   if (w_load_last) w_next = w_chk_fail ? S_UNLOAD : S_START;
            S_START:  w_next = S_RUN;
            S_RUN:    if (core_done) w_next = S_UNLOAD;
            S_UNLOAD: if (w_unload_last) w_next = S_LOAD;
            default:  w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_LOAD;
            r_cnt        <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_core_go    <= 1'b0;
            r_core_reset <= 1'b1;
            r_msg        <= '0;
            r_exp        <= '0;
            r_mod        <= '0;
            r_result     <= '0;
        end else begin
            r_state      <= w_next;
            r_in_ready   <= (w_next == S_LOAD);
            r_out_valid  <= (w_next == S_UNLOAD);
            r_core_go    <= (w_next == S_RUN);
            r_core_reset <= (w_next == S_LOAD);
            if (w_in_xfer) begin
                r_cnt <= w_load_last ? '0 : r_cnt + 1'b1;
                case (w_sel)
                    2'd0:    r_msg[w_idx*WORD +: WORD] <= in_data;
                    2'd1:    r_exp[w_idx*WORD +: WORD] <= in_data;
                    default: r_mod[w_idx*WORD +: WORD] <= in_data;
                endcase
            end else if (w_out_xfer) begin
                r_cnt <= w_unload_last ? '0 : r_cnt + 1'b1;
            end
            // A failed check bypasses the core and streams out zeros.
            if (r_state == S_RUN && core_done)
                r_result <= core_cypher;
            else if (w_load_last && w_chk_fail)
                r_result <= '0;
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_valid ? r_result[r_cnt*WORD +: WORD] : '0;
    assign busy       = (r_state != S_LOAD);
    assign core_go    = r_core_go;
    assign core_reset = r_core_reset;
    assign message    = r_msg;
    assign exponent   = r_exp;
    assign modulus    = r_mod;
endmodule

// File: tb/tb_rsa_stream_loader.sv
// Bench for rsa_stream_loader: behavioural rsa4k stand-in plus scenario tasks against a modexp/XOR reference.
module tb_rsa_stream_loader;
    localparam int WIDTH = 4096;
    localparam int WORD  = 32;
    localparam int N     = WIDTH / WORD;
`ifdef RSA_MOD_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [WORD-1:0]  in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WORD-1:0]  out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy, error, core_reset, core_go;
    logic [WIDTH-1:0] message, exponent, modulus, core_cypher;
    logic             core_done;

    logic             emu_done;
    logic [WIDTH-1:0] emu_cyp;
    int               emu_cnt;
    int               emu_lat = 3;
    int               core_mode = 0;
    logic             tb_pulse = 1'b0;
    int               n_chk = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    rsa_stream_loader #(.WIDTH(WIDTH), .WORD(WORD)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .error(error), .core_reset(core_reset), .core_go(core_go),
        .message(message), .exponent(exponent), .modulus(modulus),
        .core_cypher(core_cypher), .core_done(core_done)
    );

    function automatic logic [63:0] modexp(logic [63:0] b, logic [63:0] e, logic [63:0] m);
        logic [63:0] r;
        r = 64'd1 % m;
        b = b % m;
        while (e != 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return r;
    endfunction

    // Mode 0: real modexp on small operands; mode 1: full-width fold exposing word placement.
    function automatic logic [WIDTH-1:0] core_model(logic [WIDTH-1:0] m, logic [WIDTH-1:0] e,
                                                    logic [WIDTH-1:0] md);
        if (core_mode == 0)
            return WIDTH'(modexp({32'd0, m[31:0]}, {32'd0, e[31:0]}, {32'd0, md[31:0]}));
        return m ^ {e[WIDTH-WORD-1:0], e[WIDTH-1:WIDTH-WORD]} ^ md;
    endfunction

    always @(posedge clk) begin
        if (core_reset) begin
            emu_done <= 1'b0;
            emu_cnt  <= 0;
            emu_cyp  <= '0;
        end else if (core_go && !emu_done) begin
            if (emu_cnt >= emu_lat) begin
                emu_done <= 1'b1;
                emu_cyp  <= core_model(message, exponent, modulus);
            end else begin
                emu_cnt <= emu_cnt + 1;
            end
        end
    end

    assign core_done   = emu_done | tb_pulse;
    assign core_cypher = tb_pulse ? {(WIDTH/16){16'hDEAD}} : emu_cyp;

    task automatic run_op(input string nm, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                          input logic [WIDTH-1:0] md, input bit tog, input bit pulse,
                          input int stall, output logic [WIDTH-1:0] got);
        logic [WIDTH-1:0] exp_res;
        logic [WORD-1:0]  held;
        bit exp_err, stable_ok, saw_go, err_chk_done;
        int i, cyc, k, st, bad, first;
        bit v;
        exp_err = CHK && ((m >= md) || !md[0]);
        exp_res = exp_err ? '0 : core_model(m, e, md);
        got = '0;
        i = 0; cyc = 0; err_chk_done = 0;
        while (i < 3*N && cyc < 4000) begin
            v = tog ? (cyc % 2 == 0) : 1'b1;
            in_valid = v;
            in_data = (i < N) ? m[(i%N)*WORD +: WORD] :
                      (i < 2*N) ? e[(i%N)*WORD +: WORD] : md[(i%N)*WORD +: WORD];
            if (v && in_ready) i++;
            @(negedge clk); cyc++;
            if (i == 1 && !err_chk_done) begin
                err_chk_done = 1;
                n_chk++;
                if (error !== 1'b0) begin n_fail++; $display("FAIL %s err_clear: got %b want 0", nm, error); end
            end
        end
        in_valid = 1'b0;
        n_chk++;
        if (i != 3*N) begin n_fail++; $display("FAIL %s load_timeout: got %0d words want %0d", nm, i, 3*N); end
        if (exp_err) begin
            n_chk++;
            if ({out_valid, error, core_go} !== 3'b110)
                begin n_fail++; $display("FAIL %s err_path: got vld/err/go=%b%b%b want 110", nm, out_valid, error, core_go); end
        end else begin
            n_chk++;
            if ({core_go, busy, in_ready} !== 3'b010)
                begin n_fail++; $display("FAIL %s start_state: got go/busy/rdy=%b%b%b want 010", nm, core_go, busy, in_ready); end
            tb_pulse = pulse;
            @(negedge clk);
            tb_pulse = 1'b0;
            n_chk++;
            if (core_go !== 1'b1) begin n_fail++; $display("FAIL %s go_latency: got %b want 1", nm, core_go); end
            n_chk++;
            if (message !== m || exponent !== e || modulus !== md)
                begin n_fail++; $display("FAIL %s operands: got m/e/n lsw %h %h %h want %h %h %h", nm,
                      message[31:0], exponent[31:0], modulus[31:0], m[31:0], e[31:0], md[31:0]); end
        end
        k = 0; cyc = 0; st = 0; stable_ok = 1; saw_go = 0;
        while (k < N && cyc < 3000) begin
            if (core_go) saw_go = 1;
            if (stall == 1 && k == N/2 && st < 5) begin
                out_ready = 1'b0;
                if (st == 0) held = out_data;
                else if (out_data !== held) stable_ok = 0;
                st++;
            end else if (stall == 2) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin got[k*WORD +: WORD] = out_data; k++; end
            @(negedge clk); cyc++;
        end
        out_ready = 1'b0;
        bad = 0; first = -1;
        for (int w = 0; w < N; w++)
            if (got[w*WORD +: WORD] !== exp_res[w*WORD +: WORD]) begin
                bad++;
                if (first < 0) first = w;
            end
        n_chk++;
        if (k != N || bad != 0)
            begin n_fail++; $display("FAIL %s result: got %0d words, %0d wrong (first %0d: %h want %h)", nm, k, bad,
                  first, (first < 0) ? 32'h0 : got[((first<0)?0:first)*WORD +: WORD],
                  (first < 0) ? 32'h0 : exp_res[((first<0)?0:first)*WORD +: WORD]); end
        if (exp_err) begin
            n_chk++;
            if (saw_go) begin n_fail++; $display("FAIL %s go_on_error: got 1 want 0", nm); end
        end
        if (stall == 1) begin
            n_chk++;
            if (!stable_ok || st != 5) begin n_fail++; $display("FAIL %s stall_stable: got ok=%0d cycles=%0d want 1/5", nm, stable_ok, st); end
        end
        n_chk++;
        if ({busy, in_ready, out_valid, core_reset, error} !== {4'b0101, exp_err})
            begin n_fail++; $display("FAIL %s end_state: got busy/rdy/vld/crst/err=%b%b%b%b%b want 0101%b", nm,
                  busy, in_ready, out_valid, core_reset, error, exp_err); end
    endtask

    task automatic test_reset();
        n_chk++;
        if ({in_ready, out_valid, busy, error, core_go, core_reset} !== 6'b000001 || out_data !== '0 ||
            message !== '0 || exponent !== '0 || modulus !== '0)
            begin n_fail++; $display("FAIL reset_vals: got rdy/vld/busy/err/go/crst=%b%b%b%b%b%b od=%h", in_ready,
                  out_valid, busy, error, core_go, core_reset, out_data); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_encrypt();
        logic [WIDTH-1:0] g;
        run_op("encrypt", WIDTH'(8), WIDTH'(13), WIDTH'(77), 0, 0, 0, g);
        n_chk++;
        if (g !== WIDTH'(32'h32)) begin n_fail++; $display("FAIL encrypt_const: got %h want 32", g[31:0]); end
    endtask

    task automatic test_decrypt();
        logic [WIDTH-1:0] g;
        run_op("decrypt", WIDTH'(50), WIDTH'(37), WIDTH'(77), 0, 0, 0, g);
        n_chk++;
        if (g !== WIDTH'(32'h08)) begin n_fail++; $display("FAIL decrypt_const: got %h want 08", g[31:0]); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] g;
        run_op("bpress", WIDTH'(8), WIDTH'(13), WIDTH'(77), 1, 0, 1, g);
    endtask

    task automatic test_reset_mid_run();
        logic [WIDTH-1:0] g;
        int i;
        emu_lat = 50;
        i = 0;
        while (i < 3*N) begin
            in_valid = 1'b1;
            in_data = (i == 0) ? 32'd8 : (i == N) ? 32'd13 : (i == 2*N) ? 32'd77 : 32'd0;
            if (in_ready) i++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        n_chk++;
        if (core_go !== 1'b1) begin n_fail++; $display("FAIL abort_pre_go: got %b want 1", core_go); end
        reset = 1'b0;
        #1;
        n_chk++;
        if ({core_go, core_reset, busy, in_ready, out_valid} !== 5'b01000 || message !== '0 || modulus !== '0)
            begin n_fail++; $display("FAIL abort_state: got go/crst/busy/rdy/vld=%b%b%b%b%b", core_go, core_reset,
                  busy, in_ready, out_valid); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        emu_lat = 3;
        run_op("reload", WIDTH'(8), WIDTH'(13), WIDTH'(77), 0, 0, 0, g);
        n_chk++;
        if (g !== WIDTH'(32'h32)) begin n_fail++; $display("FAIL reload_const: got %h want 32", g[31:0]); end
    endtask

    task automatic test_mod_check();
        logic [WIDTH-1:0] g;
        run_op("msg_ge_mod", WIDTH'(80), WIDTH'(13), WIDTH'(77), 0, 0, 0, g);
        run_op("mod_even", WIDTH'(8), WIDTH'(13), WIDTH'(78), 0, 0, 0, g);
        run_op("after_err", WIDTH'(8), WIDTH'(13), WIDTH'(77), 0, 0, 0, g);
    endtask

    task automatic test_done_in_start();
        logic [WIDTH-1:0] g;
        run_op("done_start", WIDTH'(8), WIDTH'(13), WIDTH'(77), 0, 1, 0, g);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] m, e, md, g;
        logic [31:0] mm;
        core_mode = 1;
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < N; w++) begin
                m[w*WORD +: WORD] = $urandom;
                e[w*WORD +: WORD] = $urandom;
                md[w*WORD +: WORD] = $urandom;
            end
            m[WIDTH-1] = 1'b0; md[WIDTH-1] = 1'b1; md[0] = 1'b1;
            emu_lat = $urandom_range(0, 6);
            run_op("rand_wide", m, e, md, r[0], 0, 2, g);
        end
        core_mode = 0;
        for (int r = 0; r < 2; r++) begin
            mm = $urandom_range(3, 60000) | 32'd1;
            run_op("rand_small", WIDTH'($urandom_range(0, 60000) % mm), WIDTH'($urandom), WIDTH'(mm), 0, 0, 2, g);
        end
        emu_lat = 3;
    endtask

    initial begin
        #23;
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_reset_mid_run();
        test_mod_check();
        test_done_in_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
